// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state encoding and requester IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory port signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              In_Fetch_req;
    logic [ADDR_W-1:0] In_Fetch_addr;
    logic              Out_Fetch_done;
    logic [DATA_W-1:0] Out_Fetch_data;
    logic              In_Data_req;
    logic              In_Data_R_Wbar;
    logic [ADDR_W-1:0] In_Data_addr;
    logic [DATA_W-1:0] In_Data_wdata;
    logic              Out_Data_done;
    logic [DATA_W-1:0] Out_Data_rdata;
    logic              Out_Mem_Access_en;
    logic              Out_Mem_Access_R_Wbar;
    logic [ADDR_W-1:0] Out_Mem_Access_addr;
    logic [DATA_W-1:0] Out_Mem_Write_data;
    logic [DATA_W-1:0] In_Mem_Read_data;
    logic              Out_Busy;

    modport slave (
        input  In_Fetch_req, In_Fetch_addr,
        input  In_Data_req, In_Data_R_Wbar, In_Data_addr, In_Data_wdata,
        input  In_Mem_Read_data,
        output Out_Fetch_done, Out_Fetch_data, Out_Data_done, Out_Data_rdata,
        output Out_Mem_Access_en, Out_Mem_Access_R_Wbar, Out_Mem_Access_addr,
        output Out_Mem_Write_data, Out_Busy
    );

    modport master (
        output In_Fetch_req, In_Fetch_addr,
        output In_Data_req, In_Data_R_Wbar, In_Data_addr, In_Data_wdata,
        output In_Mem_Read_data,
        input  Out_Fetch_done, Out_Fetch_data, Out_Data_done, Out_Data_rdata,
        input  Out_Mem_Access_en, Out_Mem_Access_R_Wbar, Out_Mem_Access_addr,
        input  Out_Mem_Write_data, Out_Busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Each grant runs ACCESS for 1+WAIT_CYCLES cycles, then a single DONE cycle with the done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input logic               In_clock,
    input logic               In_reset,
    mem_port_arbiter_if.slave bus
);

    localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_grant;
    logic              w_nextGrant;
    logic              r_lastGrant;
    logic              w_startAccess;
    logic              w_accessLast;
    logic [CNT_W-1:0]  r_waitCnt;
    logic [ADDR_W-1:0] r_memAddr;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_memRead;
    logic              w_nextRead;
    logic [DATA_W-1:0] r_fetchData;
    logic [DATA_W-1:0] r_dataRdata;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    function automatic logic rrPick(input logic fetchReq, input logic dataReq, input logic lastGrant);
        return (fetchReq && dataReq) ? ~lastGrant : (dataReq ? REQ_DATA : REQ_FETCH);
    endfunction

    assign w_accessLast = (r_state == S_ACCESS) && (r_waitCnt == CNT_LAST);

    always_comb begin
        w_nextState   = r_state;
        w_nextGrant   = r_grant;
        w_startAccess = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.In_Fetch_req || bus.In_Data_req) begin
                    w_nextState   = S_ACCESS;
                    w_nextGrant   = rrPick(bus.In_Fetch_req, bus.In_Data_req, r_lastGrant);
                    w_startAccess = 1'b1;
                end
            end
            S_ACCESS: begin
                if (w_accessLast) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                // The requester just served still holds req this cycle, so only the other one counts.
                if ((r_grant == REQ_FETCH) ? bus.In_Data_req : bus.In_Fetch_req) begin
                    w_nextState   = S_ACCESS;
                    w_nextGrant   = ~r_grant;
                    w_startAccess = 1'b1;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        w_nextAddr = (w_nextGrant == REQ_DATA) ? bus.In_Data_addr : bus.In_Fetch_addr;
        w_nextRead = (w_nextGrant == REQ_DATA) ? bus.In_Data_R_Wbar : 1'b1;
    end

    always_ff @(posedge In_clock or posedge In_reset) begin
        if (In_reset) begin
            r_state     <= S_IDLE;
            r_grant     <= REQ_FETCH;
            r_lastGrant <= REQ_DATA;
            r_waitCnt   <= '0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_memRead   <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_nextGrant;
            if (w_startAccess) begin
                r_memAddr  <= w_nextAddr;
                r_memWdata <= bus.In_Data_wdata;
                r_memRead  <= w_nextRead;
            end
            if ((r_state == S_ACCESS) && !w_accessLast) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end else begin
                r_waitCnt <= '0;
            end
            if (w_accessLast) begin
                r_lastGrant <= r_grant;
            end
        end
    end

    always_ff @(posedge In_clock or posedge In_reset) begin
        if (In_reset) begin
            r_fetchData <= '0;
            r_dataRdata <= '0;
        end else if (w_accessLast && r_memRead) begin
            if (r_grant == REQ_FETCH) begin
                r_fetchData <= bus.In_Mem_Read_data;
            end else begin
                r_dataRdata <= bus.In_Mem_Read_data;
            end
        end
    end

    // Writes enable only in the last ACCESS cycle so memory commits exactly once.
    assign bus.Out_Mem_Access_en     = (r_state == S_ACCESS) && (r_memRead || w_accessLast);
    assign bus.Out_Mem_Access_R_Wbar = (r_state == S_ACCESS) ? r_memRead : 1'b1;
    assign bus.Out_Mem_Access_addr   = r_memAddr;
    assign bus.Out_Mem_Write_data    = r_memWdata;
    assign bus.Out_Busy              = (r_state != S_IDLE);
    assign bus.Out_Fetch_done        = (r_state == S_DONE) && (r_grant == REQ_FETCH);
    assign bus.Out_Data_done         = (r_state == S_DONE) && (r_grant == REQ_DATA);
    assign bus.Out_Fetch_data        = r_fetchData;
    assign bus.Out_Data_rdata        = r_dataRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios on WAIT_CYCLES=0 and 2,
// plus randomized traffic against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int W0 = 0;
    localparam int W2 = 2;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W0)) dut0 (
        .In_clock(clk), .In_reset(rst), .bus(bus0)
    );
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W2)) dut2 (
        .In_clock(clk), .In_reset(rst), .bus(bus2)
    );

    logic [15:0] mem0 [0:63];
    logic [15:0] mem2 [0:63];
    logic        poke0En;
    logic [5:0]  poke0Addr;
    logic [15:0] poke0Data;
    logic        poke2En;
    logic [5:0]  poke2Addr;
    logic [15:0] poke2Data;
    int          vectors = 0;
    int          miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories: combinational read, one write per enabled write cycle.
    always @(posedge clk) begin
        if (poke0En) mem0[poke0Addr] <= poke0Data;
        else if (bus0.Out_Mem_Access_en && !bus0.Out_Mem_Access_R_Wbar)
            mem0[bus0.Out_Mem_Access_addr[5:0]] <= bus0.Out_Mem_Write_data;
    end
    always @(posedge clk) begin
        if (poke2En) mem2[poke2Addr] <= poke2Data;
        else if (bus2.Out_Mem_Access_en && !bus2.Out_Mem_Access_R_Wbar)
            mem2[bus2.Out_Mem_Access_addr[5:0]] <= bus2.Out_Mem_Write_data;
    end
    assign bus0.In_Mem_Read_data = mem0[bus0.Out_Mem_Access_addr[5:0]];
    assign bus2.In_Mem_Read_data = mem2[bus2.Out_Mem_Access_addr[5:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleNeg();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        bus0.In_Fetch_req = 1'b0; bus0.In_Fetch_addr = '0;
        bus0.In_Data_req = 1'b0; bus0.In_Data_R_Wbar = 1'b1;
        bus0.In_Data_addr = '0; bus0.In_Data_wdata = '0;
        bus2.In_Fetch_req = 1'b0; bus2.In_Fetch_addr = '0;
        bus2.In_Data_req = 1'b0; bus2.In_Data_R_Wbar = 1'b1;
        bus2.In_Data_addr = '0; bus2.In_Data_wdata = '0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sampleNeg();
    endtask

    task automatic poke0(input logic [5:0] a, input logic [15:0] d);
        poke0En = 1'b1; poke0Addr = a; poke0Data = d;
        tick();
        poke0En = 1'b0;
        sampleNeg();
    endtask

    task automatic poke2(input logic [5:0] a, input logic [15:0] d);
        poke2En = 1'b1; poke2Addr = a; poke2Data = d;
        tick();
        poke2En = 1'b0;
        sampleNeg();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        poke0(6'd23, 16'hFFFF);
        vectors++;
        if ({bus0.Out_Fetch_done, bus0.Out_Data_done, bus0.Out_Mem_Access_en, bus0.Out_Busy, bus0.Out_Mem_Access_R_Wbar} !== 5'b00001) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl0: got %b want 00001", {bus0.Out_Fetch_done, bus0.Out_Data_done, bus0.Out_Mem_Access_en, bus0.Out_Busy, bus0.Out_Mem_Access_R_Wbar});
        end
        vectors++;
        if ({bus0.Out_Fetch_data, bus0.Out_Data_rdata, bus0.Out_Mem_Access_addr, bus0.Out_Mem_Write_data} !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data0: got %h want 0", {bus0.Out_Fetch_data, bus0.Out_Data_rdata, bus0.Out_Mem_Access_addr, bus0.Out_Mem_Write_data});
        end
        vectors++;
        if ({bus2.Out_Fetch_done, bus2.Out_Data_done, bus2.Out_Mem_Access_en, bus2.Out_Busy, bus2.Out_Mem_Access_R_Wbar} !== 5'b00001) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl2: got %b want 00001", {bus2.Out_Fetch_done, bus2.Out_Data_done, bus2.Out_Mem_Access_en, bus2.Out_Busy, bus2.Out_Mem_Access_R_Wbar});
        end
        tick();
        rst = 1'b0;
        sampleNeg();
        // Cycle 0: write request; cycle 1 is the only ACCESS cycle, reset lands mid-cycle.
        tick();
        bus0.In_Data_req = 1'b1; bus0.In_Data_R_Wbar = 1'b0;
        bus0.In_Data_addr = 16'd23; bus0.In_Data_wdata = 16'hBEEF;
        sampleNeg();
        tick();
        sampleNeg();
        vectors++;
        if ({bus0.Out_Mem_Access_en, bus0.Out_Mem_Access_R_Wbar} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_write: got %b want 10", {bus0.Out_Mem_Access_en, bus0.Out_Mem_Access_R_Wbar});
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({bus0.Out_Fetch_done, bus0.Out_Data_done, bus0.Out_Mem_Access_en, bus0.Out_Busy, bus0.Out_Mem_Access_R_Wbar} !== 5'b00001) begin
                miscompares++;
                $display("[TB] FAIL reset_abort_ctrl k=%0d: got %b want 00001", k, {bus0.Out_Fetch_done, bus0.Out_Data_done, bus0.Out_Mem_Access_en, bus0.Out_Busy, bus0.Out_Mem_Access_R_Wbar});
            end
            vectors++;
            if ({bus0.Out_Data_rdata, bus0.Out_Mem_Access_addr, bus0.Out_Mem_Write_data} !== 48'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_abort_data k=%0d: got %h want 0", k, {bus0.Out_Data_rdata, bus0.Out_Mem_Access_addr, bus0.Out_Mem_Write_data});
            end
            tick();
            sampleNeg();
        end
        tick();
        bus0.In_Data_req = 1'b0;
        rst = 1'b0;
        sampleNeg();
        vectors++;
        if (mem0[23] !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_no_commit: got %h want ffff", mem0[23]);
        end
        vectors++;
        if (bus0.Out_Data_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_done: got %b want 0", bus0.Out_Data_done);
        end
    endtask

    task automatic test_fetch();
        poke0(6'd0, 16'h801D);
        tick();
        bus0.In_Fetch_req = 1'b1; bus0.In_Fetch_addr = 16'd0;
        sampleNeg();
        vectors++;
        if ({bus0.Out_Busy, bus0.Out_Mem_Access_en} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL fetch_c0: got %b want 00", {bus0.Out_Busy, bus0.Out_Mem_Access_en});
        end
        tick();
        sampleNeg();
        vectors++;
        if ({bus0.Out_Mem_Access_en, bus0.Out_Mem_Access_R_Wbar, bus0.Out_Busy, bus0.Out_Fetch_done, bus0.Out_Mem_Access_addr} !== {4'b1110, 16'd0}) begin
            miscompares++;
            $display("[TB] FAIL fetch_c1: got %h want %h", {bus0.Out_Mem_Access_en, bus0.Out_Mem_Access_R_Wbar, bus0.Out_Busy, bus0.Out_Fetch_done, bus0.Out_Mem_Access_addr}, {4'b1110, 16'd0});
        end
        tick();
        sampleNeg();
        vectors++;
        if ({bus0.Out_Fetch_done, bus0.Out_Mem_Access_en, bus0.Out_Fetch_data} !== {2'b10, 16'h801D}) begin
            miscompares++;
            $display("[TB] FAIL fetch_c2: got %h want %h", {bus0.Out_Fetch_done, bus0.Out_Mem_Access_en, bus0.Out_Fetch_data}, {2'b10, 16'h801D});
        end
        tick();
        bus0.In_Fetch_req = 1'b0;
        sampleNeg();
        vectors++;
        if ({bus0.Out_Busy, bus0.Out_Fetch_done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL fetch_no_regrant: got %b want 00", {bus0.Out_Busy, bus0.Out_Fetch_done});
        end
    endtask

    task automatic test_write_read();
        int wrCycles = 0;
        tick();
        bus0.In_Data_req = 1'b1; bus0.In_Data_R_Wbar = 1'b0;
        bus0.In_Data_addr = 16'd40; bus0.In_Data_wdata = 16'h1234;
        sampleNeg();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                tick();
                bus0.In_Data_req = 1'b0;
                sampleNeg();
            end else begin
                tick();
                sampleNeg();
            end
            if (bus0.Out_Mem_Access_en && !bus0.Out_Mem_Access_R_Wbar) wrCycles++;
            vectors++;
            if (bus0.Out_Data_done !== (c == 2)) begin
                miscompares++;
                $display("[TB] FAIL wr_done c=%0d: got %b want %b", c, bus0.Out_Data_done, (c == 2));
            end
        end
        vectors++;
        if (wrCycles !== 1) begin
            miscompares++;
            $display("[TB] FAIL wr_en_cycles: got %0d want 1", wrCycles);
        end
        vectors++;
        if (mem0[40] !== 16'h1234) begin
            miscompares++;
            $display("[TB] FAIL wr_commit: got %h want 1234", mem0[40]);
        end
        tick();
        bus0.In_Data_req = 1'b1; bus0.In_Data_R_Wbar = 1'b1; bus0.In_Data_addr = 16'd40;
        sampleNeg();
        tick();
        sampleNeg();
        tick();
        sampleNeg();
        vectors++;
        if ({bus0.Out_Data_done, bus0.Out_Data_rdata, bus0.Out_Fetch_data} !== {1'b1, 16'h1234, 16'h801D}) begin
            miscompares++;
            $display("[TB] FAIL rd_after_wr: got %h want %h", {bus0.Out_Data_done, bus0.Out_Data_rdata, bus0.Out_Fetch_data}, {1'b1, 16'h1234, 16'h801D});
        end
        tick();
        bus0.In_Data_req = 1'b0;
        sampleNeg();
    endtask

    task automatic test_simultaneous();
        logic expF;
        logic expD;
        logic expEn;
        applyReset();
        poke0(6'd20, 16'h0001);
        poke0(6'd21, 16'h000F);
        tick();
        bus0.In_Fetch_req = 1'b1; bus0.In_Fetch_addr = 16'd20;
        bus0.In_Data_req = 1'b1; bus0.In_Data_R_Wbar = 1'b1; bus0.In_Data_addr = 16'd21;
        sampleNeg();
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 7) bus0.In_Fetch_req = 1'b0;
            sampleNeg();
            expF  = (c == 2) || (c == 6);
            expD  = (c == 4) || (c == 8);
            expEn = (c % 2) == 1;
            vectors++;
            if ({bus0.Out_Fetch_done, bus0.Out_Data_done, bus0.Out_Mem_Access_en} !== {expF, expD, expEn}) begin
                miscompares++;
                $display("[TB] FAIL alt_ctrl c=%0d: got %b want %b", c, {bus0.Out_Fetch_done, bus0.Out_Data_done, bus0.Out_Mem_Access_en}, {expF, expD, expEn});
            end
            if (expEn) begin
                vectors++;
                if (bus0.Out_Mem_Access_addr !== (((c == 1) || (c == 5)) ? 16'd20 : 16'd21)) begin
                    miscompares++;
                    $display("[TB] FAIL alt_addr c=%0d: got %0d", c, bus0.Out_Mem_Access_addr);
                end
            end
            if (c == 2) begin
                vectors++;
                if (bus0.Out_Fetch_data !== 16'h0001) begin
                    miscompares++;
                    $display("[TB] FAIL alt_fetch_data: got %h want 0001", bus0.Out_Fetch_data);
                end
            end
            if (c == 4) begin
                vectors++;
                if (bus0.Out_Data_rdata !== 16'h000F) begin
                    miscompares++;
                    $display("[TB] FAIL alt_data_rdata: got %h want 000f", bus0.Out_Data_rdata);
                end
            end
        end
        tick();
        bus0.In_Data_req = 1'b0;
        sampleNeg();
        vectors++;
        if (bus0.Out_Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL alt_idle: got %b want 0", bus0.Out_Busy);
        end
    endtask

    task automatic test_done_arrival();
        applyReset();
        poke0(6'd22, 16'hA5C3);
        tick();
        bus0.In_Fetch_req = 1'b1; bus0.In_Fetch_addr = 16'd0;
        sampleNeg();
        tick();
        sampleNeg();
        tick();
        bus0.In_Data_req = 1'b1; bus0.In_Data_R_Wbar = 1'b1; bus0.In_Data_addr = 16'd22;
        sampleNeg();
        vectors++;
        if ({bus0.Out_Fetch_done, bus0.Out_Data_done} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL arr_c2: got %b want 10", {bus0.Out_Fetch_done, bus0.Out_Data_done});
        end
        tick();
        bus0.In_Fetch_req = 1'b0;
        sampleNeg();
        vectors++;
        if ({bus0.Out_Mem_Access_en, bus0.Out_Fetch_done, bus0.Out_Mem_Access_addr} !== {2'b10, 16'd22}) begin
            miscompares++;
            $display("[TB] FAIL arr_c3: got %h want %h", {bus0.Out_Mem_Access_en, bus0.Out_Fetch_done, bus0.Out_Mem_Access_addr}, {2'b10, 16'd22});
        end
        tick();
        sampleNeg();
        vectors++;
        if ({bus0.Out_Data_done, bus0.Out_Fetch_done, bus0.Out_Data_rdata} !== {2'b10, 16'hA5C3}) begin
            miscompares++;
            $display("[TB] FAIL arr_c4: got %h want %h", {bus0.Out_Data_done, bus0.Out_Fetch_done, bus0.Out_Data_rdata}, {2'b10, 16'hA5C3});
        end
        tick();
        bus0.In_Data_req = 1'b0;
        sampleNeg();
    endtask

    task automatic test_wait_cycles();
        poke2(6'd24, 16'h0045);
        tick();
        bus2.In_Data_req = 1'b1; bus2.In_Data_R_Wbar = 1'b1; bus2.In_Data_addr = 16'd24;
        sampleNeg();
        for (int c = 1; c <= 4; c++) begin
            tick();
            sampleNeg();
            vectors++;
            if ({bus2.Out_Mem_Access_en, bus2.Out_Busy, bus2.Out_Data_done} !== {(c <= 3), 1'b1, (c == 4)}) begin
                miscompares++;
                $display("[TB] FAIL wait_rd c=%0d: got %b want %b", c, {bus2.Out_Mem_Access_en, bus2.Out_Busy, bus2.Out_Data_done}, {(c <= 3), 1'b1, (c == 4)});
            end
        end
        vectors++;
        if (bus2.Out_Data_rdata !== 16'h0045) begin
            miscompares++;
            $display("[TB] FAIL wait_rd_data: got %h want 0045", bus2.Out_Data_rdata);
        end
        tick();
        bus2.In_Data_req = 1'b0;
        sampleNeg();
        tick();
        bus2.In_Data_req = 1'b1; bus2.In_Data_R_Wbar = 1'b0;
        bus2.In_Data_addr = 16'd30; bus2.In_Data_wdata = 16'h7E57;
        sampleNeg();
        for (int c = 1; c <= 4; c++) begin
            tick();
            sampleNeg();
            vectors++;
            if ({bus2.Out_Mem_Access_en, bus2.Out_Mem_Access_R_Wbar, bus2.Out_Data_done} !== {(c == 3), (c == 4), (c == 4)}) begin
                miscompares++;
                $display("[TB] FAIL wait_wr c=%0d: got %b want %b", c, {bus2.Out_Mem_Access_en, bus2.Out_Mem_Access_R_Wbar, bus2.Out_Data_done}, {(c == 3), (c == 4), (c == 4)});
            end
        end
        tick();
        bus2.In_Data_req = 1'b0;
        sampleNeg();
        vectors++;
        if ({mem2[30], bus2.Out_Data_rdata} !== {16'h7E57, 16'h0045}) begin
            miscompares++;
            $display("[TB] FAIL wait_wr_commit: got %h want %h", {mem2[30], bus2.Out_Data_rdata}, {16'h7E57, 16'h0045});
        end
    endtask

    // Transaction-level model: the port serves one request at a time, each finishing 2+W cycles
    // after its grant; an idle port grants immediately, a DONE cycle hands over to the other side.
    task automatic test_random();
        logic [15:0] refMem [0:63];
        logic        fPend = 1'b0, dPend = 1'b0, fDrop = 1'b0, dDrop = 1'b0;
        logic        dRead = 1'b1, fWant, dWant, mServing = 1'b0, mLast = 1'b1;
        logic [5:0]  fAddr = '0, dAddr = '0;
        logic [15:0] dWdata = '0, v;
        int          fExp = -1, dExp = -1, mDoneAt = -1, wrCnt = 0;
        applyReset();
        for (int i = 0; i < 64; i++) begin
            v = 16'($urandom);
            refMem[i] = v;
            poke0(6'(i), v);
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (fDrop) begin
                bus0.In_Fetch_req = 1'b0; fPend = 1'b0; fDrop = 1'b0;
            end else if (!fPend && $urandom_range(0, 2) == 0) begin
                fAddr = 6'($urandom_range(0, 63));
                bus0.In_Fetch_req = 1'b1; bus0.In_Fetch_addr = {10'd0, fAddr}; fPend = 1'b1;
            end
            if (dDrop) begin
                bus0.In_Data_req = 1'b0; dPend = 1'b0; dDrop = 1'b0;
            end else if (!dPend && $urandom_range(0, 2) == 0) begin
                dAddr = 6'($urandom_range(0, 63));
                dRead = 1'($urandom_range(0, 1));
                dWdata = 16'($urandom);
                bus0.In_Data_req = 1'b1; bus0.In_Data_R_Wbar = dRead;
                bus0.In_Data_addr = {10'd0, dAddr}; bus0.In_Data_wdata = dWdata; dPend = 1'b1;
            end
            if (mDoneAt == cyc) begin
                if (mServing ? (fPend && fExp < 0) : (dPend && dExp < 0)) begin
                    mServing = ~mServing; mLast = mServing; mDoneAt = cyc + 2 + W0;
                    if (mServing) dExp = mDoneAt; else fExp = mDoneAt;
                end else begin
                    mDoneAt = -1;
                end
            end else if (mDoneAt < 0) begin
                fWant = fPend && (fExp < 0);
                dWant = dPend && (dExp < 0);
                if (fWant || dWant) begin
                    mServing = (fWant && dWant) ? ~mLast : dWant;
                    mLast = mServing; mDoneAt = cyc + 2 + W0;
                    if (mServing) dExp = mDoneAt; else fExp = mDoneAt;
                end
            end
            sampleNeg();
            if (bus0.Out_Mem_Access_en && !bus0.Out_Mem_Access_R_Wbar) wrCnt++;
            vectors++;
            if (bus0.Out_Fetch_done !== (cyc == fExp)) begin
                miscompares++;
                $display("[TB] FAIL rand_fetch_done cyc=%0d: got %b want %b", cyc, bus0.Out_Fetch_done, (cyc == fExp));
            end
            vectors++;
            if (bus0.Out_Data_done !== (cyc == dExp)) begin
                miscompares++;
                $display("[TB] FAIL rand_data_done cyc=%0d: got %b want %b", cyc, bus0.Out_Data_done, (cyc == dExp));
            end
            if (cyc == fExp) begin
                vectors++;
                if (bus0.Out_Fetch_data !== refMem[fAddr]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_fetch_data cyc=%0d addr=%0d: got %h want %h", cyc, fAddr, bus0.Out_Fetch_data, refMem[fAddr]);
                end
                fExp = -1; fDrop = 1'b1;
            end
            if (cyc == dExp) begin
                vectors++;
                if (dRead) begin
                    if (bus0.Out_Data_rdata !== refMem[dAddr]) begin
                        miscompares++;
                        $display("[TB] FAIL rand_data_rdata cyc=%0d addr=%0d: got %h want %h", cyc, dAddr, bus0.Out_Data_rdata, refMem[dAddr]);
                    end
                end else begin
                    refMem[dAddr] = dWdata;
                    if (wrCnt !== 1) begin
                        miscompares++;
                        $display("[TB] FAIL rand_write_en cyc=%0d: got %0d enabled write cycles want 1", cyc, wrCnt);
                    end
                end
                wrCnt = 0; dExp = -1; dDrop = 1'b1;
            end
        end
        tick();
        clearInputs();
        for (int k = 0; k < 6; k++) tick();
        sampleNeg();
    endtask

    initial begin
        poke0En = 1'b0; poke0Addr = '0; poke0Data = '0;
        poke2En = 1'b0; poke2Addr = '0; poke2Data = '0;
        test_reset();
        test_fetch();
        test_write_read();
        test_simultaneous();
        test_done_arrival();
        test_wait_cycles();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single shared memory port between two requesters: the instruction-fetch path and the load/store data path of the multicycle processor.
- Sits between the control/datapath and the unified 16-bit memory. Drives the memory's access-enable, read/write, address and write-data inputs, and registers the memory's read data back to the winning requester.
- Uses round-robin arbitration with a fixed, parameterisable access length and a one-cycle done pulse per transaction.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WAIT_CYCLES, 0, extra cycles the port is held per access; the ACCESS phase lasts 1+WAIT_CYCLES cycles.

Ports:
- In_clock  in  1  system clock, rising edge.
- In_reset  in  1  asynchronous, active-high reset.
- In_Fetch_req  in  1  fetch request; held until Out_Fetch_done.
- In_Fetch_addr  in  ADDR_W  fetch address; stable while requesting.
- Out_Fetch_done  out  1  one-cycle completion pulse.
- Out_Fetch_data  out  DATA_W  registered instruction word.
- In_Data_req  in  1  load/store request; held until Out_Data_done.
- In_Data_R_Wbar  in  1  1 = read, 0 = write.
- In_Data_addr  in  ADDR_W  data address.
- In_Data_wdata  in  DATA_W  store data.
- Out_Data_done  out  1  one-cycle completion pulse.
- Out_Data_rdata  out  DATA_W  registered load data.
- Out_Mem_Access_en  out  1  memory access enable.
- Out_Mem_Access_R_Wbar  out  1  memory read(1)/write(0).
- Out_Mem_Access_addr  out  ADDR_W  memory address.
- Out_Mem_Write_data  out  DATA_W  memory write data.
- In_Mem_Read_data  in  DATA_W  memory read data (combinational from address).
- Out_Busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (async, In_reset=1):
  - State returns to IDLE; wait counter is cleared.
  - last_grant is set to DATA, so FETCH wins the first tie.
  - All done outputs, read-data registers, Out_Busy and Out_Mem_Access_en are 0.
  - Out_Mem_Access_R_Wbar=1; address and write data are 0.
  - Reset mid-access aborts the transaction: no done pulse is issued and no write is committed.
- States:
  - IDLE: no grant.
  - ACCESS: the memory port is driven for the granted requester (grant register fixed on entry).
  - DONE: one cycle; done pulse asserted.
- Transitions:
  - IDLE: no request -> stay in IDLE. One request -> ACCESS for that requester. Both requesting -> grant the requester opposite to last_grant.
  - ACCESS: counter runs 0..WAIT_CYCLES. At WAIT_CYCLES -> DONE; read data is captured at that edge.
  - DONE: the just-served requester's req is ignored (it is still high this cycle). If the other requester's req is high -> ACCESS for it. Otherwise -> IDLE. last_grant is updated on leaving ACCESS.
- Memory port in ACCESS:
  - Address, R_Wbar and write data come from the granted requester. Fetch is always a read.
  - Reads: en=1 throughout ACCESS.
  - Writes: en=1 only in the final ACCESS cycle, so the memory commits exactly one write at the ACCESS->DONE edge.
  - Outside ACCESS: en=0 and R_Wbar=1. Address and data hold their last values; no one relies on them.
- Read capture:
  - At the ACCESS->DONE edge, In_Mem_Read_data is loaded into Out_Fetch_data or Out_Data_rdata (read accesses only).
  - The register holds until the next read completion for that requester.
  - A data write does not change Out_Data_rdata.
- Latency:
  - A request first seen in IDLE in cycle 0 gives ACCESS in cycles 1..1+WAIT_CYCLES and the done pulse in cycle 2+WAIT_CYCLES.
  - A back-to-back grant to the other requester from DONE skips IDLE.
  - Per-requester throughput is at most one transaction every 3+WAIT_CYCLES cycles.
- Requester rule: req, addr, R_Wbar and wdata stay stable from assertion until the done cycle. Changing them earlier is illegal and not checked.
- Out_Busy = (state != IDLE).
- The block has no queueing and no error response.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2;
  - requester IDs REQ_FETCH=1'b0, REQ_DATA=1'b1.
- The block is a single module; no sub-module is needed. The round-robin choice is a two-line function within the module.

Test Plan:
1. Reset during ACCESS of a data write of 16'hBEEF to addr 23 (WAIT_CYCLES=0) -> no Out_Data_done pulse; mem[23] keeps its preload 16'hFFFF; all outputs are 0 and R_Wbar=1 while reset is held.
2. Fetch only: memory preloaded mem[0]=16'h801D; In_Fetch_req=1 with addr 0 asserted in cycle 0 -> Out_Mem_Access_en=1 with addr 0 in cycle 1; Out_Fetch_done=1 and Out_Fetch_data=16'h801D in cycle 2.
3. Data write then read: write 16'h1234 to addr 40 -> en=1 and R_Wbar=0 for exactly one cycle, done in cycle 2. A following read of addr 40 -> Out_Data_rdata=16'h1234 and Out_Fetch_data unchanged.
4. Simultaneous requests after reset: fetch addr 20 (preloaded 16'h0001) and data read addr 21 (preloaded 16'h000F) -> fetch is served first (done at cycle 2, data 16'h0001). Data goes directly DONE->ACCESS and completes at cycle 4 with 16'h000F. Both requests held continuously -> the two alternate.
5. WAIT_CYCLES=2 read of addr 24 (preloaded 16'h0045) -> ACCESS holds for 3 cycles, done in cycle 4. A write under WAIT_CYCLES=2 -> en is high only in the third ACCESS cycle.
6. Request arriving in DONE: fetch done in cycle 2 while data req rises in cycle 2 -> ACCESS for data in cycle 3. The fetch req still high in its own DONE cycle does not cause a re-grant.
